// File: rtl/egress_frame_finalizer.sv
// Egress frame finalizer: enforces min/max Ethernet frame sizes on an AXI-Stream.
// Short frames are zero-padded to MIN_FRAME_BYTES; long frames are cut at
// MAX_PACKET_LENGTH and the remainder of the input frame is swallowed.
// A single output register stage gives one cycle of latency.
module egress_frame_finalizer #(
  parameter int unsigned AXIS_BUS_WIDTH    = 64,
  parameter int unsigned AXIS_ID_WIDTH     = 4,
  parameter int unsigned AXIS_DEST_WIDTH   = 4,
  parameter int unsigned MIN_FRAME_BYTES   = 60,
  parameter int unsigned MAX_PACKET_LENGTH = 1522,
  localparam int unsigned EffIdWidth   = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
  localparam int unsigned EffDestWidth = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
  localparam int unsigned Lanes        = AXIS_BUS_WIDTH / 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic [EffIdWidth-1:0]     axis_in_tid,
  input  logic [EffDestWidth-1:0]   axis_in_tdest,
  input  logic [Lanes-1:0]          axis_in_tkeep,
  input  logic                      axis_in_tlast,
  input  logic                      axis_in_tvalid,
  output logic                      axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
  output logic [EffIdWidth-1:0]     axis_out_tid,
  output logic [EffDestWidth-1:0]   axis_out_tdest,
  output logic [Lanes-1:0]          axis_out_tkeep,
  output logic                      axis_out_tlast,
  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready,
  output logic                      pad_event,
  output logic                      trunc_event
);

  typedef enum logic [1:0] {StPass, StPad, StDrop} state_e;

  // Length arithmetic is done on 17 bits so cnt + nb never wraps.
  localparam logic [16:0] MinLen   = 17'(MIN_FRAME_BYTES);
  localparam logic [16:0] MaxLen   = 17'(MAX_PACKET_LENGTH);
  localparam logic [16:0] LanesLen = 17'(Lanes);

  // Number of set bits in a keep vector.
  function automatic logic [16:0] popcount(input logic [Lanes-1:0] k);
    logic [16:0] n;
    n = '0;
    for (int i = 0; i < int'(Lanes); i++) n = n + 17'(k[i]);
    return n;
  endfunction

  // Contiguous-from-LSB keep with n lanes set (saturates at all lanes).
  function automatic logic [Lanes-1:0] keep_from_count(input logic [16:0] n);
    logic [Lanes-1:0] m;
    for (int i = 0; i < int'(Lanes); i++) m[i] = (17'(i) < n);
    return m;
  endfunction

  // Expand a per-lane keep into a per-bit data mask.
  function automatic logic [AXIS_BUS_WIDTH-1:0] byte_mask(input logic [Lanes-1:0] k);
    logic [AXIS_BUS_WIDTH-1:0] m;
    for (int i = 0; i < int'(Lanes); i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_e                    state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [EffIdWidth-1:0]     id_lat_q, id_lat_d;
  logic [EffDestWidth-1:0]   dest_lat_q, dest_lat_d;

  logic [AXIS_BUS_WIDTH-1:0] tdata_q, tdata_d;
  logic [EffIdWidth-1:0]     tid_q, tid_d;
  logic [EffDestWidth-1:0]   tdest_q, tdest_d;
  logic [Lanes-1:0]          tkeep_q, tkeep_d;
  logic                      tlast_q, tlast_d;
  logic                      tvalid_q, tvalid_d;
  logic                      pad_ev_q, pad_ev_d;
  logic                      trunc_ev_q, trunc_ev_d;

  logic                      load;
  logic                      in_ready;
  logic                      in_accept;
  logic [16:0]               nb;
  logic [16:0]               cnt_ext;
  logic [16:0]               sum_nb;
  logic [16:0]               room_max;
  logic [16:0]               room_min;
  logic [Lanes-1:0]          keep_out;

  assign load           = !tvalid_q || axis_out_tready;
  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign axis_in_tready = in_ready & ~areset;
  assign in_accept      = axis_in_tvalid & axis_in_tready;

  assign nb       = popcount(axis_in_tkeep);
  assign cnt_ext  = {1'b0, cnt_q};
  assign sum_nb   = cnt_ext + nb;
  // Only meaningful when cnt <= MAX (PASS) or cnt < MIN (pad paths).
  assign room_max = MaxLen - cnt_ext;
  assign room_min = MinLen - cnt_ext;

  // Next-state: frame-size policy and output register load.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_lat_d   = id_lat_q;
    dest_lat_d = dest_lat_q;
    tdata_d    = tdata_q;
    tid_d      = tid_q;
    tdest_d    = tdest_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q;
    pad_ev_d   = 1'b0;
    trunc_ev_d = 1'b0;
    in_ready   = 1'b0;
    keep_out   = axis_in_tkeep;

    // Drain by default; branches below reload when they produce a beat.
    if (load) tvalid_d = 1'b0;

    case (state_q)
      StPass: begin
        in_ready = load;
        if (in_accept) begin
          tvalid_d = 1'b1;
          tid_d    = axis_in_tid;
          tdest_d  = axis_in_tdest;
          if (sum_nb > MaxLen) begin
            keep_out   = keep_from_count(room_max);
            tlast_d    = 1'b1;
            trunc_ev_d = 1'b1;
            cnt_d      = '0;
            if (!axis_in_tlast) state_d = StDrop;
          end else if (axis_in_tlast && (sum_nb < MinLen)) begin
            keep_out = keep_from_count(room_min);
            if (room_min <= LanesLen) begin
              tlast_d  = 1'b1;
              pad_ev_d = 1'b1;
              cnt_d    = '0;
            end else begin
              tlast_d    = 1'b0;
              id_lat_d   = axis_in_tid;
              dest_lat_d = axis_in_tdest;
              cnt_d      = 16'(cnt_ext + LanesLen);
              state_d    = StPad;
            end
          end else begin
            keep_out = axis_in_tkeep;
            tlast_d  = axis_in_tlast;
            cnt_d    = axis_in_tlast ? 16'd0 : 16'(sum_nb);
          end
          tkeep_d = keep_out;
          // Lanes added by padding or removed by truncation come out as zero.
          tdata_d = axis_in_tdata & byte_mask(axis_in_tkeep & keep_out);
        end
      end

      StPad: begin
        if (load) begin
          tvalid_d = 1'b1;
          tdata_d  = '0;
          tid_d    = id_lat_q;
          tdest_d  = dest_lat_q;
          tkeep_d  = keep_from_count(room_min);
          if (room_min <= LanesLen) begin
            tlast_d  = 1'b1;
            pad_ev_d = 1'b1;
            cnt_d    = '0;
            state_d  = StPass;
          end else begin
            tlast_d = 1'b0;
            cnt_d   = 16'(cnt_ext + LanesLen);
          end
        end
      end

      StDrop: begin
        in_ready = 1'b1;
        if (in_accept && axis_in_tlast) state_d = StPass;
      end

      default: state_d = StPass;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= StPass;
      cnt_q      <= '0;
      id_lat_q   <= '0;
      dest_lat_q <= '0;
      tdata_q    <= '0;
      tid_q      <= '0;
      tdest_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      pad_ev_q   <= 1'b0;
      trunc_ev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_lat_q   <= id_lat_d;
      dest_lat_q <= dest_lat_d;
      tdata_q    <= tdata_d;
      tid_q      <= tid_d;
      tdest_q    <= tdest_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      pad_ev_q   <= pad_ev_d;
      trunc_ev_q <= trunc_ev_d;
    end
  end

  assign axis_out_tdata  = tdata_q;
  assign axis_out_tid    = tid_q;
  assign axis_out_tdest  = tdest_q;
  assign axis_out_tkeep  = tkeep_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tvalid = tvalid_q;
  assign pad_event       = pad_ev_q;
  assign trunc_event     = trunc_ev_q;

endmodule

// File: tb/tb_egress_frame_finalizer.sv
// Self-checking bench for egress_frame_finalizer: directed and random frames,
// checked beat by beat against a byte-level frame-size model.
module tb_egress_frame_finalizer;

  localparam int unsigned W     = 64;
  localparam int unsigned L     = W / 8;
  localparam int unsigned IdW   = 4;
  localparam int unsigned DestW = 4;
  localparam int          MinB  = 60;
  localparam int          MaxB  = 1522;

  typedef struct {
    logic [W-1:0]     data;
    logic [L-1:0]     keep;
    logic             last;
    logic [IdW-1:0]   id;
    logic [DestW-1:0] dest;
    logic             pad;
    logic             trunc;
  } beat_t;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic [W-1:0]     axis_in_tdata = '0;
  logic [IdW-1:0]   axis_in_tid = '0;
  logic [DestW-1:0] axis_in_tdest = '0;
  logic [L-1:0]     axis_in_tkeep = '0;
  logic             axis_in_tlast = 1'b0;
  logic             axis_in_tvalid = 1'b0;
  logic             axis_in_tready;
  logic [W-1:0]     axis_out_tdata;
  logic [IdW-1:0]   axis_out_tid;
  logic [DestW-1:0] axis_out_tdest;
  logic [L-1:0]     axis_out_tkeep;
  logic             axis_out_tlast;
  logic             axis_out_tvalid;
  logic             axis_out_tready;
  logic             pad_event;
  logic             trunc_event;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    exp_pad_n = 0;
  int    exp_trunc_n = 0;
  int    seen_pad_n = 0;
  int    seen_trunc_n = 0;
  bit    mon_en = 1'b0;
  bit    rand_ready = 1'b0;

  egress_frame_finalizer #(
    .AXIS_BUS_WIDTH   (W),
    .AXIS_ID_WIDTH    (IdW),
    .AXIS_DEST_WIDTH  (DestW),
    .MIN_FRAME_BYTES  (MinB),
    .MAX_PACKET_LENGTH(MaxB)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .axis_in_tdata  (axis_in_tdata),
    .axis_in_tid    (axis_in_tid),
    .axis_in_tdest  (axis_in_tdest),
    .axis_in_tkeep  (axis_in_tkeep),
    .axis_in_tlast  (axis_in_tlast),
    .axis_in_tvalid (axis_in_tvalid),
    .axis_in_tready (axis_in_tready),
    .axis_out_tdata (axis_out_tdata),
    .axis_out_tid   (axis_out_tid),
    .axis_out_tdest (axis_out_tdest),
    .axis_out_tkeep (axis_out_tkeep),
    .axis_out_tlast (axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tready(axis_out_tready),
    .pad_event      (pad_event),
    .trunc_event    (trunc_event)
  );

  initial forever #5 aclk = ~aclk;

  // Output backpressure: always ready, or a coin flip per cycle.
  initial begin
    axis_out_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      axis_out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: output is the frame clipped to MaxB, zero-extended to MinB, in L-byte beats.
  task automatic push_expected(input byte unsigned b[$], input int len,
                               input logic [IdW-1:0] id, input logic [DestW-1:0] dest);
    int olen;
    int nbeats;
    olen   = (len > MaxB) ? MaxB : ((len < MinB) ? MinB : len);
    nbeats = (olen + L - 1) / L;
    for (int k = 0; k < nbeats; k++) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int j = 0; j < L; j++) begin
        int idx;
        idx = k * L + j;
        if (idx < olen) begin
          e.keep[j]      = 1'b1;
          e.data[8*j+:8] = (idx < len) ? b[idx] : 8'h00;
        end
      end
      e.last  = (k == nbeats - 1);
      e.id    = id;
      e.dest  = dest;
      e.pad   = e.last && (len < MinB);
      e.trunc = e.last && (len > MaxB);
      exp_q.push_back(e);
    end
    if (len < MinB) exp_pad_n++;
    if (len > MaxB) exp_trunc_n++;
  endtask

  // Drive one frame of full beats (last beat partial), garbage in unused lanes.
  task automatic send_frame(input int len, input logic [IdW-1:0] id,
                            input logic [DestW-1:0] dest, input bit push);
    byte unsigned b[$];
    int nbeats;
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    if (push) push_expected(b, len, id, dest);
    nbeats = (len + L - 1) / L;
    for (int k = 0; k < nbeats; k++) begin
      logic [W-1:0] d;
      logic [L-1:0] kp;
      bit           done;
      int           t;
      d  = {$urandom, $urandom};
      kp = '0;
      for (int j = 0; j < L; j++) begin
        if (k * L + j < len) begin
          kp[j]      = 1'b1;
          d[8*j+:8]  = b[k*L+j];
        end
      end
      if (rand_ready && ($urandom_range(0, 3) == 0)) begin
        axis_in_tvalid = 1'b0;
        @(posedge aclk);
        #1;
      end
      axis_in_tdata  = d;
      axis_in_tkeep  = kp;
      axis_in_tid    = id;
      axis_in_tdest  = dest;
      axis_in_tlast  = (k == nbeats - 1);
      axis_in_tvalid = 1'b1;
      done = 1'b0;
      t    = 0;
      while (!done) begin
        @(negedge aclk);
        if (axis_in_tready) done = 1'b1;
        @(posedge aclk);
        #1;
        t++;
        if (!done && t > 2000) begin
          n_vec++;
          n_err++;
          $display("FAIL accept_timeout: observed no tready, expected tready within 2000 cycles");
          $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
          $fatal(1, "input stalled");
        end
      end
    end
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge aclk);
    repeat (3) @(posedge aclk);
    #1;
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: beat contents, event timing and stall stability.
  initial begin
    beat_t e;
    beat_t prev;
    bit    prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge aclk);
      if (!mon_en) begin
        prev_stall = 1'b0;
        continue;
      end
      if (pad_event) seen_pad_n++;
      if (trunc_event) seen_trunc_n++;
      if (prev_stall) begin
        chk("hold_data", axis_out_tdata, prev.data);
        chk("hold_ctl", 64'({axis_out_tvalid, axis_out_tkeep, axis_out_tlast, axis_out_tid,
                             axis_out_tdest}),
            64'({1'b1, prev.keep, prev.last, prev.id, prev.dest}));
      end
      if (axis_out_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 64'(axis_out_tvalid), 64'd0);
        end else begin
          e = exp_q[0];
          chk("pad_event", 64'(pad_event), 64'(prev_stall ? 1'b0 : e.pad));
          chk("trunc_event", 64'(trunc_event), 64'(prev_stall ? 1'b0 : e.trunc));
          if (axis_out_tready) begin
            chk("out_data", axis_out_tdata, e.data);
            chk("out_keep_last", 64'({axis_out_tkeep, axis_out_tlast}), 64'({e.keep, e.last}));
            chk("out_id_dest", 64'({axis_out_tid, axis_out_tdest}), 64'({e.id, e.dest}));
            void'(exp_q.pop_front());
          end
        end
        prev.data  = axis_out_tdata;
        prev.keep  = axis_out_tkeep;
        prev.last  = axis_out_tlast;
        prev.id    = axis_out_tid;
        prev.dest  = axis_out_tdest;
        prev_stall = !axis_out_tready;
      end else begin
        chk("idle_events", 64'({pad_event, trunc_event}), 64'd0);
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int lens[$];
    // Reset state.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 64'(axis_out_tvalid), 64'd0);
    chk("rst_tdata", axis_out_tdata, 64'd0);
    chk("rst_tkeep_tlast", 64'({axis_out_tkeep, axis_out_tlast}), 64'd0);
    chk("rst_events", 64'({pad_event, trunc_event}), 64'd0);
    chk("rst_tready", 64'(axis_in_tready), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    mon_en = 1'b1;

    // Directed frames with the output always ready.
    send_frame(42, 4'h3, 4'hA, 1'b1);
    drain();
    send_frame(57, 4'h5, 4'h6, 1'b1);
    drain();
    send_frame(60, 4'h1, 4'h2, 1'b1);
    send_frame(1522, 4'h7, 4'h8, 1'b1);
    drain();
    send_frame(1600, 4'h9, 4'hC, 1'b1);
    send_frame(64, 4'h4, 4'hD, 1'b1);
    drain();
    send_frame(1, 4'hE, 4'h1, 1'b1);
    send_frame(1525, 4'h2, 4'h3, 1'b1);
    drain();

    // Random backpressure, input bubbles and random lengths incl. boundaries.
    rand_ready = 1'b1;
    lens = '{42, 57, 100, 59, 60, 61, 1521, 1522, 1523, 1530};
    for (int i = 0; i < 12; i++) lens.push_back(int'($urandom_range(1, 1700)));
    foreach (lens[i]) send_frame(lens[i], 4'($urandom), 4'($urandom), 1'b1);
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("pad_event_total", 64'(seen_pad_n), 64'(exp_pad_n));
    chk("trunc_event_total", 64'(seen_trunc_n), 64'(exp_trunc_n));

    // Reset while the block is emitting pad beats of a 42-byte frame.
    mon_en = 1'b0;
    send_frame(42, 4'h6, 4'h9, 1'b0);
    areset = 1'b1;
    #1;
    chk("rst_mid_tready_now", 64'(axis_in_tready), 64'd0);
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_mid_tvalid", 64'(axis_out_tvalid), 64'd0);
    chk("rst_mid_tready", 64'(axis_in_tready), 64'd0);
    chk("rst_mid_ctl", 64'({axis_out_tkeep, axis_out_tlast, pad_event, trunc_event}), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    send_frame(64, 4'hB, 4'h5, 1'b1);
    drain();
    send_frame(42, 4'hA, 4'h4, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/egress_frame_finalizer.md
Name: egress_frame_finalizer

Overview:
- Sits directly downstream of the encapsulator output stream, ahead of the MAC TX interface.
- Enforces Ethernet frame-size limits on every frame:
  - Zero-pads short frames up to MIN_FRAME_BYTES.
  - Truncates frames that exceed MAX_PACKET_LENGTH, then drops the rest of the input frame.
- Preserves tid/tdest and raises single-cycle event pulses for the stats logic.

Parameters:
- AXIS_BUS_WIDTH, 64, data width in bits (multiple of 8, ≥ 32).
- AXIS_ID_WIDTH, 4, tid width; effective width = max(1, value).
- AXIS_DEST_WIDTH, 4, tdest width; effective width = max(1, value).
- MIN_FRAME_BYTES, 60, minimum output frame length in bytes (excluding FCS).
- MAX_PACKET_LENGTH, 1522, maximum output frame length in bytes; must be > MIN_FRAME_BYTES.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- axis_in_tdata  in  AXIS_BUS_WIDTH  input data.
- axis_in_tid  in  EFF_ID_WIDTH  input id.
- axis_in_tdest  in  EFF_DEST_WIDTH  input dest.
- axis_in_tkeep  in  AXIS_BUS_WIDTH/8  byte enables; contiguous from LSB.
- axis_in_tlast  in  1  end of frame.
- axis_in_tvalid  in  1  input valid.
- axis_in_tready  out  1  input ready.
- axis_out_tdata/tid/tdest/tkeep/tlast/tvalid  out  same widths as input  output stream.
- axis_out_tready  in  1  output ready.
- pad_event  out  1  one-cycle pulse when a frame is padded.
- trunc_event  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset:
  - All outputs are 0: out_tvalid=0, tlast=0, tkeep=0, tdata=0, events=0.
  - State = PASS, byte counter = 0.
  - axis_in_tready=0 while areset is high.
  - Reset mid-frame abandons the frame; no tlast is emitted for it.
- Output is one register stage, so latency is 1 cycle from input acceptance to output valid.
- Register load condition: load = !out_tvalid || axis_out_tready.
- Byte counter cnt is 16 bits and holds the bytes already emitted in the current frame. nb = popcount(tkeep) of the current beat.
- State PASS:
  - axis_in_tready = load.
  - On accept:
    - If cnt + nb > MAX_PACKET_LENGTH:
      - Emit the beat with tkeep cut to (MAX_PACKET_LENGTH − cnt) lanes and tlast=1.
      - Pulse trunc_event; cnt←0.
      - Next state = DROP unless in_tlast, in which case stay in PASS.
    - Else if in_tlast and cnt + nb < MIN_FRAME_BYTES:
      - Extend tkeep to min(lanes, MIN_FRAME_BYTES − cnt); force added lanes' data to 0.
      - If MIN is reached within this beat: tlast=1, cnt←0, pulse pad_event.
      - Otherwise: tlast=0, latch tid/tdest, cnt += lanes, go to PAD.
    - Else: pass the beat unchanged; cnt += nb, or cnt←0 on tlast.
- State PAD:
  - axis_in_tready=0.
  - On load, emit a beat with tdata=0, latched tid/tdest, and tkeep = min(lanes, MIN − cnt) lanes.
  - When MIN is reached: tlast=1, pulse pad_event, cnt←0, go to PASS.
- State DROP:
  - axis_in_tready=1; accepted beats are discarded and the output register is not loaded by them.
  - Accepting in_tlast returns the block to PASS.
  - Output register still drains normally.
- Event pulses assert in the same cycle the corresponding tlast beat is loaded into the output register.
- Data lanes with tkeep=0 are always driven to 0 on output.
- Output holds tdata/tkeep/tlast/tid/tdest stable while out_tvalid && !out_tready (AXI-S compliant).
- A frame of exactly MIN_FRAME_BYTES, or exactly MAX_PACKET_LENGTH, passes unmodified with no event.
- Single-beat frames follow the same rules.
- Back-to-back frames incur no idle cycle except the PAD beats.

Test Plan (64-bit bus, defaults):
- 42-byte frame (5 full beats + keep 0x03 tlast) → output:
  - 5 beats unchanged;
  - beat 6 keep 0xFF, bytes 2–7 = 0, tlast=0;
  - beat 7 all-zero, keep 0xFF;
  - beat 8 zero, keep 0x0F, tlast;
  - total 60 bytes, tid/tdest preserved, one pad_event.
- 57-byte frame (7 full + keep 0x01 tlast) → last beat keep 0x0F, bytes 1–3 = 0, tlast, pad_event; no PAD beats.
- 60-byte and 1522-byte frames → bit-exact passthrough, no events.
- 200-beat full frame → output 190 full beats + beat 191 keep 0x03 tlast, trunc_event; next 9 input beats consumed and dropped; the following 64-byte frame passes intact.
- Random axis_out_tready (50%) during PAD and during passthrough → no data change, no duplicated or lost beats; output stable while stalled.
- areset asserted during PAD of a 42-byte frame → next cycle out_tvalid=0 and tready=0; after release a new 64-byte frame passes unchanged with cnt starting at 0.
